// File: rtl/if_feeder_pkg.sv
// Shared types and constants for the IF->ID instruction feeder.
package if_feeder_pkg;

  localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0080;

  // One fetched word as it sits in the prefetch FIFO.
  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } fifo_entry_t;

  typedef enum logic {
    IDLE,
    RUN
  } feeder_state_t;

  // Fetches are word-granular; the low two address bits carry no meaning.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_feeder_fifo.sv
// Generic synchronous FIFO with flush; flush wins over a same-cycle push/pop.
module if_feeder_fifo #(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers and count alone define which entries are live.
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/if_instr_feeder.sv
// Instruction-supply side of IF->ID: OBI fetch into a prefetch FIFO, presented to ID.
module if_instr_feeder
  import if_feeder_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic        halt_if_i,
  input  logic        id_ready_i,
  input  logic        clear_instr_valid_i,
  input  logic        pc_set_i,
  input  logic [31:0] pc_target_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] pc_id_o,
  output logic        is_compressed_o,
  output logic        illegal_c_insn_o,
  output logic        is_fetch_failed_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  localparam int             CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

  feeder_state_t    state, state_next;
  logic [31:0]      fetch_addr;
  logic [31:0]      redirect_addr;     // target parked while an old request waits for its grant
  logic             redirect_pending;
  logic             req_pending;       // request raised last cycle and not yet granted
  logic [CNT_W-1:0] outstanding, outstanding_next;
  logic [CNT_W-1:0] discard, discard_next;
  logic [CNT_W:0]   in_flight;
  logic             grant, pending_after, rsp_keep, fifo_pop;
  fifo_entry_t      push_entry, head_entry;
  logic [CNT_W-1:0] fifo_count, aq_count;
  logic             fifo_full, fifo_empty, aq_full, aq_empty;
  logic [31:0]      aq_head;

  assign in_flight     = {1'b0, fifo_count} + {1'b0, outstanding};
  // New requests need a free FIFO slot per in-flight word; a pending one must stay up until granted.
  assign mem_req_o     = req_pending || (state == RUN && !pc_set_i && in_flight < DEPTH_EXT);
  assign mem_addr_o    = mem_req_o ? fetch_addr : '0;
  assign grant         = mem_req_o && mem_gnt_i;
  assign pending_after = mem_req_o && !mem_gnt_i;
  assign rsp_keep      = mem_rvalid_i && (discard == '0);
  assign push_entry    = {mem_rdata_i, aq_head, mem_err_i};

  assign instr_valid_o     = !fifo_empty && !halt_if_i && !pc_set_i;
  assign fifo_pop          = (instr_valid_o && id_ready_i) || (clear_instr_valid_i && !fifo_empty);
  assign instr_rdata_o     = fifo_empty ? '0 : head_entry.rdata;
  assign pc_id_o           = fifo_empty ? '0 : head_entry.addr;
  assign is_fetch_failed_o = !fifo_empty && head_entry.err;
  assign is_compressed_o   = 1'b0;
  assign illegal_c_insn_o  = 1'b0;

  if_feeder_fifo #(.WIDTH($bits(fifo_entry_t)), .DEPTH(DEPTH)) u_entry_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .pop   (fifo_pop),
    .flush (pc_set_i),
    .wdata (push_entry),
    .rdata (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Addresses of granted, still-wanted requests, consumed in response order.
  if_feeder_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_addr_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (grant && !redirect_pending),
    .pop   (rsp_keep),
    .flush (pc_set_i),
    .wdata (mem_addr_o),
    .rdata (aq_head),
    .count (aq_count),
    .full  (aq_full),
    .empty (aq_empty)
  );

  // Next-state, outstanding and discard bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_next       = state;
    outstanding_next = outstanding;
    discard_next     = discard;
    case (state)
      IDLE:    if (instr_req_i) state_next = RUN;
      RUN:     if (!instr_req_i && !pending_after) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    case ({grant, mem_rvalid_i})
      2'b10:   outstanding_next = outstanding + 1'b1;
      2'b01:   outstanding_next = outstanding - 1'b1;
      default: outstanding_next = outstanding;
    endcase
    // On redirect every response still owed, including a not-yet-granted request, is stale.
    if (pc_set_i)
      discard_next = outstanding_next + {{(CNT_W-1){1'b0}}, pending_after};
    else if (mem_rvalid_i && discard != '0)
      discard_next = discard - 1'b1;
  end

  // Control registers and fetch address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      fetch_addr       <= BOOT_ADDR;
      redirect_addr    <= '0;
      redirect_pending <= 1'b0;
      req_pending      <= 1'b0;
      outstanding      <= '0;
      discard          <= '0;
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      discard     <= discard_next;
      req_pending <= pending_after;
      if (pc_set_i) begin
        if (pending_after) begin
          redirect_pending <= 1'b1;
          redirect_addr    <= word_align(pc_target_i);
        end else begin
          redirect_pending <= 1'b0;
          fetch_addr       <= word_align(pc_target_i);
        end
      end else if (grant) begin
        if (redirect_pending) begin
          fetch_addr       <= redirect_addr;
          redirect_pending <= 1'b0;
        end else begin
          fetch_addr <= fetch_addr + 32'd4;
        end
      end
    end
  end

  // Structural invariants: no overflow/underflow, and every owed response is either kept or discarded.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(rsp_keep && fifo_full && !pc_set_i));
      assert (!(grant && !redirect_pending && aq_full && !pc_set_i));
      assert (!(rsp_keep && aq_empty));
      assert ({1'b0, aq_count} + {1'b0, discard} ==
              {1'b0, outstanding} + {{CNT_W{1'b0}}, redirect_pending});
    end
  end

endmodule

// File: tb/tb_if_instr_feeder.sv
// Scoreboard bench for if_instr_feeder: stimulus queues expected instructions, a monitor checks them.
module tb_if_instr_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_i, halt_if_i, id_ready_i, clear_instr_valid_i, pc_set_i;
  logic [31:0] pc_target_i;
  logic        instr_valid_o, is_compressed_o, illegal_c_insn_o, is_fetch_failed_o;
  logic [31:0] instr_rdata_o, pc_id_o;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_addr_o, mem_rdata_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rsp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          budget = 0;      // grants the memory model will still give
  int          gnt_cnt = 0;
  logic        rsp_hold = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  if_instr_feeder dut (
    .clk                 (clk),
    .rst                 (rst),
    .instr_req_i         (instr_req_i),
    .halt_if_i           (halt_if_i),
    .id_ready_i          (id_ready_i),
    .clear_instr_valid_i (clear_instr_valid_i),
    .pc_set_i            (pc_set_i),
    .pc_target_i         (pc_target_i),
    .instr_valid_o       (instr_valid_o),
    .instr_rdata_o       (instr_rdata_o),
    .pc_id_o             (pc_id_o),
    .is_compressed_o     (is_compressed_o),
    .illegal_c_insn_o    (illegal_c_insn_o),
    .is_fetch_failed_o   (is_fetch_failed_o),
    .mem_req_o           (mem_req_o),
    .mem_addr_o          (mem_addr_o),
    .mem_gnt_i           (mem_gnt_i),
    .mem_rvalid_i        (mem_rvalid_i),
    .mem_rdata_i         (mem_rdata_i),
    .mem_err_i           (mem_err_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(input logic [31:0] pc, input logic [31:0] data, input logic err);
    exp_t e;
    e.pc = pc; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_req_i = 1'b0; halt_if_i = 1'b0; id_ready_i = 1'b0;
    clear_instr_valid_i = 1'b0; pc_set_i = 1'b0; pc_target_i = '0;
    budget = 0; rsp_hold = 1'b0; err_addr = 32'hFFFF_FFFF;
    exp_q.delete();
    tick();
    tick();
    gnt_cnt = 0;
    rst = 1'b0;
  endtask

  // Memory model: grants while budget lasts, answers in order one cycle after grant unless held.
  initial begin
    logic [31:0] a;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rsp_q.delete();
      end else if (mem_req_o && mem_gnt_i) begin
        rsp_q.push_back(mem_addr_o);
        gnt_cnt++;
        budget--;
      end
      @(posedge clk);
      #2;
      mem_gnt_i = (budget > 0);
      if (!rst && !rsp_hold && rsp_q.size() > 0) begin
        a = rsp_q.pop_front();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = {a[15:0], 16'h0013};
        mem_err_i    = (a == err_addr);
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        mem_err_i    = 1'b0;
      end
    end
  end

  // Monitor: every instruction accepted by ID is compared against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid_o && id_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc_id %h, expected nothing", pc_id_o);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", pc_id_o, e.pc);
          check("instr_rdata", instr_rdata_o, e.data);
          check("instr_fetch_failed", {31'b0, is_fetch_failed_o}, {31'b0, e.err});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;

    // 1: boot fetch, latency and address stepping
    do_reset();
    budget = 3; instr_req_i = 1'b1; id_ready_i = 1'b1;
    expect_instr(32'h0000_0080, 32'h0080_0013, 1'b0);
    expect_instr(32'h0000_0084, 32'h0084_0013, 1'b0);
    expect_instr(32'h0000_0088, 32'h0088_0013, 1'b0);
    @(negedge clk);
    check("rst_instr_valid", {31'b0, instr_valid_o}, 32'h0);
    check("rst_instr_rdata", instr_rdata_o, 32'h0);
    check("rst_pc_id", pc_id_o, 32'h0);
    check("rst_fetch_failed", {31'b0, is_fetch_failed_o}, 32'h0);
    check("rst_is_compressed", {31'b0, is_compressed_o}, 32'h0);
    check("rst_illegal_c", {31'b0, illegal_c_insn_o}, 32'h0);
    check("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    tick(); @(negedge clk);
    check("t1_c1_req", {31'b0, mem_req_o}, 32'h1);
    check("t1_c1_addr", mem_addr_o, 32'h0000_0080);
    check("t1_c1_valid", {31'b0, instr_valid_o}, 32'h0);
    tick(); @(negedge clk);
    check("t1_c2_addr", mem_addr_o, 32'h0000_0084);
    check("t1_c2_valid", {31'b0, instr_valid_o}, 32'h0);
    tick(); @(negedge clk);
    check("t1_c3_valid", {31'b0, instr_valid_o}, 32'h1);
    check("t1_c3_pc", pc_id_o, 32'h0000_0080);
    tick(); @(negedge clk);
    check("t1_c4_addr", mem_addr_o, 32'h0000_0088);
    wait_drain(20, "t1_drain");
    @(negedge clk);
    check("t1_pending_req", {31'b0, mem_req_o}, 32'h1);
    check("t1_pending_addr", mem_addr_o, 32'h0000_008C);

    // 2: back-pressure limits requests to DEPTH
    do_reset();
    budget = 100; instr_req_i = 1'b1; id_ready_i = 1'b0;
    expect_instr(32'h0000_0080, 32'h0080_0013, 1'b0);
    expect_instr(32'h0000_0084, 32'h0084_0013, 1'b0);
    repeat (10) tick();
    @(negedge clk);
    check("t2_grants", gnt_cnt, 2);
    check("t2_req_low", {31'b0, mem_req_o}, 32'h0);
    check("t2_valid", {31'b0, instr_valid_o}, 32'h1);
    check("t2_pc_held", pc_id_o, 32'h0000_0080);
    tick();
    budget = 0; id_ready_i = 1'b1;
    wait_drain(20, "t2_drain");

    // 3: redirect with two requests outstanding
    do_reset();
    rsp_hold = 1'b1; budget = 2; instr_req_i = 1'b1; id_ready_i = 1'b1;
    repeat (3) tick();
    check("t3_full_no_req", {31'b0, mem_req_o}, 32'h0);
    check("t3_grants", gnt_cnt, 2);
    pc_set_i = 1'b1; pc_target_i = 32'h0000_1003; rsp_hold = 1'b0; budget = 2;
    expect_instr(32'h0000_1000, 32'h1000_0013, 1'b0);
    expect_instr(32'h0000_1004, 32'h1004_0013, 1'b0);
    tick();
    pc_set_i = 1'b0;
    @(negedge clk);
    check("t3_new_req", {31'b0, mem_req_o}, 32'h1);
    check("t3_new_addr", mem_addr_o, 32'h0000_1000);
    wait_drain(20, "t3_drain");

    // 4: grant stall keeps the request stable; redirect mid-stall
    do_reset();
    budget = 0; instr_req_i = 1'b1; id_ready_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      pc_set_i = (i == 3);
      pc_target_i = 32'h0000_2000;
      @(negedge clk);
      check("t4_stall_req", {31'b0, mem_req_o}, 32'h1);
      check("t4_stall_addr", mem_addr_o, 32'h0000_0080);
    end
    tick();
    pc_set_i = 1'b0; budget = 3;
    expect_instr(32'h0000_2000, 32'h2000_0013, 1'b0);
    expect_instr(32'h0000_2004, 32'h2004_0013, 1'b0);
    tick();
    @(negedge clk);
    check("t4_redirect_addr", mem_addr_o, 32'h0000_2000);
    wait_drain(20, "t4_drain");

    // 5: halt with full FIFO, clear drops the head
    do_reset();
    budget = 2; halt_if_i = 1'b1; instr_req_i = 1'b1; id_ready_i = 1'b1;
    expect_instr(32'h0000_0080, 32'h0080_0013, 1'b0);
    expect_instr(32'h0000_0084, 32'h0084_0013, 1'b0);
    repeat (6) tick();
    @(negedge clk);
    check("t5_halt_valid", {31'b0, instr_valid_o}, 32'h0);
    check("t5_halt_pc", pc_id_o, 32'h0000_0080);
    check("t5_halt_rdata", instr_rdata_o, 32'h0080_0013);
    check("t5_full_no_req", {31'b0, mem_req_o}, 32'h0);
    tick();
    @(negedge clk);
    check("t5_no_pop", pc_id_o, 32'h0000_0080);
    tick();
    clear_instr_valid_i = 1'b1;
    e = exp_q.pop_front();
    @(negedge clk);
    check("t5_clear_head", pc_id_o, e.pc);
    tick();
    clear_instr_valid_i = 1'b0;
    @(negedge clk);
    check("t5_after_clear_pc", pc_id_o, 32'h0000_0084);
    check("t5_after_clear_valid", {31'b0, instr_valid_o}, 32'h0);
    tick();
    halt_if_i = 1'b0;
    wait_drain(20, "t5_drain");

    // 6: bus error is presented, fetching continues; reset mid-burst
    do_reset();
    err_addr = 32'h0000_0084; budget = 100; instr_req_i = 1'b1; id_ready_i = 1'b1;
    expect_instr(32'h0000_0080, 32'h0080_0013, 1'b0);
    expect_instr(32'h0000_0084, 32'h0084_0013, 1'b1);
    expect_instr(32'h0000_0088, 32'h0088_0013, 1'b0);
    wait_drain(30, "t6_drain");
    check("t6_busy_before_rst", {31'b0, instr_valid_o}, 32'h1);
    rst = 1'b1; budget = 0; instr_req_i = 1'b0; id_ready_i = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", {31'b0, instr_valid_o}, 32'h0);
    check("t6_rst_rdata", instr_rdata_o, 32'h0);
    check("t6_rst_pc", pc_id_o, 32'h0);
    check("t6_rst_fetch_failed", {31'b0, is_fetch_failed_o}, 32'h0);
    check("t6_rst_mem_req", {31'b0, mem_req_o}, 32'h0);
    check("t6_rst_mem_addr", mem_addr_o, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
